sib_multi_mode_sampler: RTL and testbench
=========================================

Name: sib_multi_mode_sampler

Overview:
- Parametrised SampleInBall engine for ML-DSA-44/65/87. Builds the challenge polynomial c (256 coefficients in {-1,0,+1}, exactly tau nonzero) from a SHAKE256 byte stream.
- Sits between the Keccak core output and the NTT/multiply datapath.
- Generalises the fixed single-mode SIB flow:
  - runtime tau selection by mode;
  - configurable input beat width with an internal beat buffer;
  - local coefficient store with a registered read port.

Parameters:
BYTES_PER_CYCLE, 8, input beat width in bytes; legal values 1, 2, 4, 8.
TAU_MODE0, 39, tau for ML-DSA-44.
TAU_MODE1, 49, tau for ML-DSA-65.
TAU_MODE2, 60, tau for ML-DSA-87; every TAU must be at most 64.

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
zeroize  in  1  synchronous clear of all state, same effect as reset
start_i  in  1  start pulse
mode_i  in  2  tau select (0/1/2); sampled at start; 3 is illegal
data_i  in  8*BYTES_PER_CYCLE  SHAKE bytes; byte 0 = data_i[7:0] is consumed first
data_valid_i  in  1  beat valid
data_ready_o  out  1  beat accepted when valid and ready are both high
busy_o  out  1  high in SIGN_BUFFER or ACTIVE
done_o  out  1  one-cycle pulse on completion
error_o  out  1  one-cycle pulse on start with mode 3
rd_en_i  in  1  coefficient read request
rd_addr_i  in  8  coefficient index
rd_data_o  out  2  coefficient code: 00 = 0, 01 = +1, 11 = -1
rd_valid_o  out  1  rd_data_o valid, one cycle after rd_en_i

Behaviour:
- Reset and zeroize:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Coefficient store, sign register, index and beat buffer are cleared.
  - Reset or zeroize mid-operation aborts with no done_o.
- State SIB_IDLE:
  - data_ready_o = 0.
  - start_i with mode 0..2: latch tau, clear the store (single cycle), set index i = 256 - tau, go to SIB_SIGN_BUFFER.
  - start_i with mode 3: pulse error_o, stay in IDLE.
- State SIB_SIGN_BUFFER:
  - data_ready_o = 1.
  - Accept 8/BYTES_PER_CYCLE beats. They form a 64-bit little-endian sign word s; the first byte is s[7:0].
  - After the last sign beat, go to SIB_ACTIVE.
  - Sign bytes never reach the sampler, even if a beat is wider.
- State SIB_ACTIVE:
  - The beat buffer holds one beat and consumes one byte per cycle.
  - data_ready_o = 1 when the buffer is empty, or when its last byte is consumed this cycle. This gives back-to-back beats with no bubble.
  - Each consumed byte is a candidate j (0..255).
  - j > i: reject and discard the byte. i and s are unchanged.
  - j <= i: accept. In the same cycle:
    - c[i] <= old c[j];
    - c[j] <= (s[0] ? -1 : +1);
    - s shifts right by 1;
    - i <= i + 1.
  - j == i: the c[j] write wins, so c[i] = ±1.
  - Accept with i == 255: go to SIB_DONE. Unconsumed bytes in the buffer are dropped, and data_ready_o = 0 from the next cycle.
  - An empty buffer with data_valid_i low stalls processing; no state change.
- State SIB_DONE:
  - Pulse done_o for one cycle, then return to SIB_IDLE.
  - The store holds its result until the next start_i, reset or zeroize.
- Start handling: start_i while busy_o is high is ignored (no error_o).
- Reads:
  - Legal in any state.
  - rd_data_o = c[rd_addr_i] as sampled at the rising edge with rd_en_i, registered, 1-cycle latency.
  - A read and a write to the same index in the same cycle returns the pre-write value.
  - rd_data_o holds its value when rd_en_i is low.
- Latency: minimum start-to-done_o is 1 + 8/BYTES_PER_CYCLE + tau + 1 cycles, assuming zero rejections and an always-valid stream.
- Invariant at done_o: exactly tau nonzero coefficients. Each nonzero has the sign given by sign bits s[0..tau-1], applied in order of acceptance.

Test Plan:
- Mode 0, BYTES_PER_CYCLE=8:
  - Stimulus: sign beat 0x0000_0000_0000_0001, then candidate bytes 0x05, 0xFF, 0xDA, …
  - Required response: c[5] = -1 (i = 217); 0xFF is rejected at i = 218; j = 218 == i gives c[218] = +1.
  - After 39 accepts: done_o pulses once and exactly 39 nonzero coefficients read back.
- Mode 2:
  - Stimulus: all-zero sign word; candidates j = 0, 0, 0, … (60 accepts).
  - Required response: c[0] = +1; c[196..255] = +1 except where moved; nonzero count = 60; the latency formula holds exactly.
- Mode 3 start:
  - Required response: error_o pulses, busy_o stays 0, data_ready_o stays 0.
  - A following start with mode 1 completes with 49 nonzero coefficients.
- Stall and backpressure, BYTES_PER_CYCLE=1:
  - Stimulus: randomly drop data_valid_i.
  - Required response: result matches a software SampleInBall model; data_ready_o = 0 in IDLE and DONE.
- Reset and zeroize mid-operation:
  - Stimulus: rst_b low, or zeroize high, during ACTIVE at i = 230.
  - Required response: all outputs 0, all coefficients read 00, no done_o. The next start runs cleanly.
- Read during ACTIVE:
  - Stimulus: a read and an accepted write to the same index in one cycle.
  - Required response: the old value returns.
  - Also: start_i issued while busy is ignored.

Source files
------------

// File: rtl/sib_multi_mode_sampler_if.sv
// Handshake and read-port bundle for the SampleInBall engine.
// The master side drives the stream and read requests; the slave side is the sampler.
interface sib_multi_mode_sampler_if #(
  parameter int unsigned BYTES_PER_CYCLE = 8
);
  logic                           start_i;
  logic [1:0]                     mode_i;
  logic [8*BYTES_PER_CYCLE-1:0]   data_i;
  logic                           data_valid_i;
  logic                           data_ready_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           error_o;
  logic                           rd_en_i;
  logic [7:0]                     rd_addr_i;
  logic [1:0]                     rd_data_o;
  logic                           rd_valid_o;

  modport master (
    output start_i, mode_i, data_i, data_valid_i, rd_en_i, rd_addr_i,
    input  data_ready_o, busy_o, done_o, error_o, rd_data_o, rd_valid_o
  );

  modport slave (
    input  start_i, mode_i, data_i, data_valid_i, rd_en_i, rd_addr_i,
    output data_ready_o, busy_o, done_o, error_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/sib_multi_mode_sampler.sv
// SampleInBall challenge-polynomial engine for ML-DSA-44/65/87 with runtime tau,
// configurable beat width and a local coefficient store behind a registered read port.
module sib_multi_mode_sampler #(
  parameter int unsigned BYTES_PER_CYCLE = 8,
  parameter int unsigned TAU_MODE0       = 39,
  parameter int unsigned TAU_MODE1       = 49,
  parameter int unsigned TAU_MODE2       = 60
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     zeroize,
  sib_multi_mode_sampler_if.slave  bus
);

  localparam int unsigned BEAT_W     = 8 * BYTES_PER_CYCLE;
  localparam int unsigned SIGN_BEATS = 8 / BYTES_PER_CYCLE;
  localparam logic [1:0]  CODE_POS   = 2'b01;
  localparam logic [1:0]  CODE_NEG   = 2'b11;

  typedef enum logic [1:0] {
    SIB_IDLE,
    SIB_SIGN_BUFFER,
    SIB_ACTIVE,
    SIB_DONE
  } state_t;

  state_t              state;
  logic [1:0]          coef [256];
  logic [63:0]         sign_q;
  logic [7:0]          idx_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [3:0]          beat_cnt;
  logic [3:0]          sign_cnt;
  logic [7:0]          cand;
  logic [7:0]          start_idx;
  logic [63:0]         beat_ext;
  logic                ready;
  logic                take_beat;
  logic                byte_ok;
  logic                accept;

  assign cand     = beat_q[7:0];
  assign beat_ext = 64'(bus.data_i);

  always_comb begin
    ready = 1'b0;
    case (state)
      SIB_SIGN_BUFFER: ready = 1'b1;
      SIB_ACTIVE:      ready = (beat_cnt <= 4'd1);
      default:         ready = 1'b0;
    endcase
    take_beat = ready && bus.data_valid_i;
    byte_ok   = (state == SIB_ACTIVE) && (beat_cnt != 4'd0);
    accept    = byte_ok && (cand <= idx_q);
    case (bus.mode_i)
      2'd0:    start_idx = 8'(9'd256 - 9'(TAU_MODE0));
      2'd1:    start_idx = 8'(9'd256 - 9'(TAU_MODE1));
      2'd2:    start_idx = 8'(9'd256 - 9'(TAU_MODE2));
      default: start_idx = '0;
    endcase
  end

  assign bus.data_ready_o = ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= SIB_IDLE;
      sign_q         <= '0;
      idx_q          <= '0;
      beat_q         <= '0;
      beat_cnt       <= '0;
      sign_cnt       <= '0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.error_o    <= 1'b0;
      bus.rd_data_o  <= '0;
      bus.rd_valid_o <= 1'b0;
      for (int unsigned k = 0; k < 256; k++) coef[k] <= '0;
    end else if (zeroize) begin
      state          <= SIB_IDLE;
      sign_q         <= '0;
      idx_q          <= '0;
      beat_q         <= '0;
      beat_cnt       <= '0;
      sign_cnt       <= '0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.error_o    <= 1'b0;
      bus.rd_data_o  <= '0;
      bus.rd_valid_o <= 1'b0;
      for (int unsigned k = 0; k < 256; k++) coef[k] <= '0;
    end else begin
      bus.done_o     <= 1'b0;
      bus.error_o    <= 1'b0;
      bus.rd_valid_o <= bus.rd_en_i;
      if (bus.rd_en_i) bus.rd_data_o <= coef[bus.rd_addr_i];

      case (state)
        SIB_IDLE: begin
          if (bus.start_i) begin
            if (bus.mode_i == 2'd3) begin
              bus.error_o <= 1'b1;
            end else begin
              for (int unsigned k = 0; k < 256; k++) coef[k] <= '0;
              idx_q      <= start_idx;
              sign_cnt   <= '0;
              beat_cnt   <= '0;
              bus.busy_o <= 1'b1;
              state      <= SIB_SIGN_BUFFER;
            end
          end
        end

        SIB_SIGN_BUFFER: begin
          if (take_beat) begin
            // Beats enter at the top so the first byte ends up in sign_q[7:0].
            sign_q   <= (sign_q >> BEAT_W) | (beat_ext << (64 - BEAT_W));
            sign_cnt <= sign_cnt + 4'd1;
            if (sign_cnt == 4'(SIGN_BEATS - 1)) state <= SIB_ACTIVE;
          end
        end

        SIB_ACTIVE: begin
          if (byte_ok) begin
            beat_q   <= beat_q >> 8;
            beat_cnt <= beat_cnt - 4'd1;
          end
          if (take_beat) begin
            beat_q   <= bus.data_i;
            beat_cnt <= 4'(BYTES_PER_CYCLE);
          end
          if (accept) begin
            // Second write wins when cand == idx_q, leaving c[i] = +/-1.
            coef[idx_q] <= coef[cand];
            coef[cand]  <= sign_q[0] ? CODE_NEG : CODE_POS;
            sign_q      <= sign_q >> 1;
            idx_q       <= idx_q + 8'd1;
            if (idx_q == 8'hFF) begin
              state      <= SIB_DONE;
              bus.busy_o <= 1'b0;
              bus.done_o <= 1'b1;
              beat_cnt   <= '0;
            end
          end
        end

        SIB_DONE: state <= SIB_IDLE;

        default: state <= SIB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sib_multi_mode_sampler.sv
// Scoreboard bench for sib_multi_mode_sampler: an 8-byte-beat instance and a
// 1-byte-beat instance share clock and reset; read responses are checked by a monitor.
module tb_sib_multi_mode_sampler;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic zeroize = 1'b0;

  always #5 clk = ~clk;

  sib_multi_mode_sampler_if #(.BYTES_PER_CYCLE(8)) bus8 ();
  sib_multi_mode_sampler_if #(.BYTES_PER_CYCLE(1)) bus1 ();

  sib_multi_mode_sampler #(
    .BYTES_PER_CYCLE(8), .TAU_MODE0(39), .TAU_MODE1(49), .TAU_MODE2(60)
  ) dut8 (.clk(clk), .rst_b(rst_b), .zeroize(zeroize), .bus(bus8));

  sib_multi_mode_sampler #(
    .BYTES_PER_CYCLE(1), .TAU_MODE0(39), .TAU_MODE1(49), .TAU_MODE2(60)
  ) dut1 (.clk(clk), .rst_b(rst_b), .zeroize(zeroize), .bus(bus1));

  int tests = 0;
  int fails = 0;

  logic [9:0] exp_q8[$];
  logic [9:0] exp_q1[$];
  int nz8 = 0, nz1 = 0;
  int done8 = 0, done1 = 0, err8 = 0, err1 = 0;

  logic [7:0] jbytes[$];
  logic [1:0] mc[256];

  int         j_stall = 0;
  int         j_abort_cyc = 0;
  int         j_abort_kind = 0;
  int         j_rd_cyc = 0;
  int         j_bs_cyc = 0;
  logic [7:0] j_rd_addr = '0;
  logic [1:0] j_rd_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-response monitor and event counters.
  always @(negedge clk) begin
    logic [9:0] e;
    if (bus8.done_o)  done8++;
    if (bus1.done_o)  done1++;
    if (bus8.error_o) err8++;
    if (bus1.error_o) err1++;
    if (bus8.rd_valid_o) begin
      if (exp_q8.size() == 0) check("rd8_unexpected_valid", 64'(bus8.rd_valid_o), 0);
      else begin
        e = exp_q8.pop_front();
        check($sformatf("rd8_c[%0d]", e[9:2]), 64'(bus8.rd_data_o), 64'(e[1:0]));
        if (bus8.rd_data_o != 2'b00) nz8++;
      end
    end
    if (bus1.rd_valid_o) begin
      if (exp_q1.size() == 0) check("rd1_unexpected_valid", 64'(bus1.rd_valid_o), 0);
      else begin
        e = exp_q1.pop_front();
        check($sformatf("rd1_c[%0d]", e[9:2]), 64'(bus1.rd_data_o), 64'(e[1:0]));
        if (bus1.rd_data_o != 2'b00) nz1++;
      end
    end
  end

  function automatic logic o_ready(input int w);
    return (w != 0) ? bus1.data_ready_o : bus8.data_ready_o;
  endfunction
  function automatic logic o_busy(input int w);
    return (w != 0) ? bus1.busy_o : bus8.busy_o;
  endfunction
  function automatic logic o_done(input int w);
    return (w != 0) ? bus1.done_o : bus8.done_o;
  endfunction
  function automatic logic o_error(input int w);
    return (w != 0) ? bus1.error_o : bus8.error_o;
  endfunction

  task automatic drv(input int w, input logic st, input logic [1:0] md, input logic vld,
                     input logic [63:0] dat, input logic re, input logic [7:0] ra);
    if (w != 0) begin
      bus1.start_i = st; bus1.mode_i = md; bus1.data_valid_i = vld;
      bus1.data_i = dat[7:0]; bus1.rd_en_i = re; bus1.rd_addr_i = ra;
    end else begin
      bus8.start_i = st; bus8.mode_i = md; bus8.data_valid_i = vld;
      bus8.data_i = dat; bus8.rd_en_i = re; bus8.rd_addr_i = ra;
    end
  endtask

  task automatic push_exp(input int w, input logic [7:0] a, input logic [1:0] v);
    if (w != 0) exp_q1.push_back({a, v});
    else        exp_q8.push_back({a, v});
  endtask

  // Reference SampleInBall: for i = 256-tau..255 draw j until j <= i, swap in sign.
  function automatic void model(input int tau, input logic [63:0] sign);
    int p = 0;
    int k = 0;
    logic [7:0] j;
    foreach (mc[a]) mc[a] = 2'b00;
    for (int i = 256 - tau; i < 256; i++) begin
      do begin
        j = (p < jbytes.size()) ? jbytes[p] : 8'h00;
        p++;
      end while (int'(j) > i);
      mc[i] = mc[j];
      mc[j] = sign[k] ? 2'b11 : 2'b01;
      k++;
    end
  endfunction

  task automatic run_job(input int w, input logic [1:0] mode, input logic [63:0] sign,
                         output int lat, output bit done_seen);
    int bpc, nb, sent, pos;
    bit vld;
    logic st, re;
    logic [1:0] md;
    logic [7:0] ra;
    logic [63:0] beat;
    bpc = (w != 0) ? 1 : 8;
    nb = 8 / bpc;
    sent = 0; pos = 0; lat = 0; done_seen = 0;
    @(negedge clk);
    drv(w, 1'b1, mode, 1'b0, '0, 1'b0, '0);
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      if (o_done(w)) begin
        done_seen = 1;
        lat = cyc;
        check("ready_low_in_done", 64'(o_ready(w)), 0);
        check("busy_low_in_done", 64'(o_busy(w)), 0);
        break;
      end
      if (cyc == j_abort_cyc) begin
        drv(w, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
        if (j_abort_kind == 1) begin
          rst_b = 1'b0;
          repeat (2) @(negedge clk);
          rst_b = 1'b1;
        end else begin
          zeroize = 1'b1;
          @(negedge clk);
          zeroize = 1'b0;
        end
        break;
      end
      st = 1'b0; md = mode; re = 1'b0; ra = '0;
      if (cyc == j_bs_cyc) begin
        st = 1'b1; md = 2'd3;
        check("busy_during_restart", 64'(o_busy(w)), 1);
      end
      if (cyc == j_rd_cyc) begin
        re = 1'b1; ra = j_rd_addr;
        push_exp(w, j_rd_addr, j_rd_exp);
      end
      vld = ($urandom_range(99) >= j_stall);
      if (sent < nb) beat = sign >> (sent * 8 * bpc);
      else begin
        beat = '0;
        for (int b = 0; b < bpc; b++)
          if (pos + b < jbytes.size()) beat[8*b +: 8] = jbytes[pos + b];
      end
      drv(w, st, md, vld, beat, re, ra);
      #1;
      if (vld && o_ready(w)) begin
        if (sent < nb) sent++;
        else pos += bpc;
      end
    end
    drv(w, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    if (j_abort_cyc == 0) check("job_reached_done", 64'(done_seen), 1);
  endtask

  task automatic post_job(input int w, input string tag, input int d_before);
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(o_ready(w)), 0);
    check({tag, "_idle_busy"}, 64'(o_busy(w)), 0);
    check({tag, "_done_is_pulse"}, 64'(o_done(w)), 0);
    check({tag, "_done_count"}, 64'(((w != 0) ? done1 : done8) - d_before), 1);
  endtask

  task automatic readback_all(input int w, input int tau, input string tag);
    if (w != 0) nz1 = 0; else nz8 = 0;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      drv(w, 1'b0, 2'd0, 1'b0, '0, 1'b1, 8'(a));
      push_exp(w, 8'(a), mc[a]);
    end
    @(negedge clk);
    drv(w, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check({tag, "_nonzero_count"}, 64'((w != 0) ? nz1 : nz8), 64'(tau));
  endtask

  task automatic rd1(input int w, input logic [7:0] a, input logic [1:0] v);
    @(negedge clk);
    drv(w, 1'b0, 2'd0, 1'b0, '0, 1'b1, a);
    push_exp(w, a, v);
    @(negedge clk);
    drv(w, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
  endtask

  task automatic load_t1();
    jbytes.delete();
    jbytes.push_back(8'h05);
    jbytes.push_back(8'hFF);
    jbytes.push_back(8'hDA);
    for (int k = 10; k <= 46; k++) jbytes.push_back(8'(k));
    for (int k = 0; k < 8; k++) jbytes.push_back(8'h00);
  endtask

  task automatic load_zeros();
    jbytes.delete();
    for (int k = 0; k < 80; k++) jbytes.push_back(8'h00);
  endtask

  task automatic abort_test(input int kind, input string tag);
    int lat, d0;
    bit dn;
    load_zeros();
    d0 = done8;
    j_abort_cyc = 16; j_abort_kind = kind;
    run_job(0, 2'd0, 64'h1, lat, dn);
    j_abort_cyc = 0;
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus8.data_ready_o), 0);
    check({tag, "_busy"}, 64'(bus8.busy_o), 0);
    check({tag, "_done"}, 64'(bus8.done_o), 0);
    check({tag, "_error"}, 64'(bus8.error_o), 0);
    check({tag, "_rd_valid"}, 64'(bus8.rd_valid_o), 0);
    check({tag, "_rd_data"}, 64'(bus8.rd_data_o), 0);
    foreach (mc[a]) mc[a] = 2'b00;
    readback_all(0, 0, {tag, "_cleared"});
    check({tag, "_no_done"}, 64'(done8 - d0), 0);
    load_t1();
    model(39, 64'h1);
    d0 = done8;
    run_job(0, 2'd0, 64'h1, lat, dn);
    post_job(0, {tag, "_rerun"}, d0);
    readback_all(0, 39, {tag, "_rerun"});
  endtask

  initial begin
    #2ms;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int lat, d0, e0;
    bit dn;
    drv(0, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    drv(1, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus8.data_ready_o), 0);
    check("rst_busy", 64'(bus8.busy_o), 0);
    check("rst_done", 64'(bus8.done_o), 0);
    check("rst_error", 64'(bus8.error_o), 0);
    check("rst_rd_valid", 64'(bus8.rd_valid_o), 0);
    check("rst_rd_data", 64'(bus8.rd_data_o), 0);
    check("rst_ready_b1", 64'(bus1.data_ready_o), 0);

    // Mode 0 directed vector, read-vs-write collision on c[5], start while busy.
    load_t1();
    model(39, 64'h1);
    j_rd_cyc = 3; j_rd_addr = 8'd5; j_rd_exp = 2'b00; j_bs_cyc = 6;
    d0 = done8; e0 = err8;
    run_job(0, 2'd0, 64'h1, lat, dn);
    j_rd_cyc = 0; j_bs_cyc = 0;
    post_job(0, "m0", d0);
    check("m0_latency_one_reject", 64'(lat), 43);
    check("m0_start_while_busy_no_error", 64'(err8 - e0), 0);
    readback_all(0, 39, "m0");
    rd1(0, 8'd5, 2'b11);
    rd1(0, 8'd218, 2'b01);
    rd1(0, 8'd217, 2'b00);
    rd1(0, 8'd46, 2'b01);

    // Mode 2, all-zero candidates: exact minimum latency.
    load_zeros();
    model(60, 64'h0);
    d0 = done8;
    run_job(0, 2'd2, 64'h0, lat, dn);
    post_job(0, "m2", d0);
    check("m2_latency", 64'(lat), 1 + 1 + 60 + 1);
    readback_all(0, 60, "m2");
    rd1(0, 8'd0, 2'b01);
    rd1(0, 8'd196, 2'b00);
    rd1(0, 8'd255, 2'b01);

    // Illegal mode, then mode 1.
    e0 = err8;
    @(negedge clk);
    drv(0, 1'b1, 2'd3, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    drv(0, 1'b0, 2'd0, 1'b0, '0, 1'b0, '0);
    check("m3_error_pulse", 64'(bus8.error_o), 1);
    check("m3_busy", 64'(bus8.busy_o), 0);
    check("m3_ready", 64'(bus8.data_ready_o), 0);
    @(negedge clk);
    check("m3_error_cleared", 64'(bus8.error_o), 0);
    check("m3_error_count", 64'(err8 - e0), 1);
    jbytes.delete();
    for (int k = 0; k < 300; k++) jbytes.push_back(8'((k * 97 + 3) & 255));
    model(49, 64'h0123_4567_89AB_CDEF);
    d0 = done8;
    run_job(0, 2'd1, 64'h0123_4567_89AB_CDEF, lat, dn);
    post_job(0, "m1", d0);
    readback_all(0, 49, "m1");

    // One-byte beats with random valid drops and frequent rejections.
    jbytes.delete();
    for (int k = 0; k < 400; k++) jbytes.push_back(8'((k * 73 + 11) & 255));
    model(39, 64'hA5C3_0F1E_9B27_6D48);
    check("b1_idle_ready", 64'(bus1.data_ready_o), 0);
    j_stall = 30;
    d0 = done1;
    run_job(1, 2'd0, 64'hA5C3_0F1E_9B27_6D48, lat, dn);
    j_stall = 0;
    post_job(1, "b1", d0);
    readback_all(1, 39, "b1");

    abort_test(1, "rst_abort");
    abort_test(2, "zero_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
